// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution compute stage.
package conv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_OUT,
    S_DONE
  } conv_state_t;

  // Holds K^2 full-precision products plus the bias without wrapping.
  function automatic int conv_outw(input int inw, input int maxk);
    return 2 * inw + $clog2(maxk * maxk + 1);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate: load_bias seeds the accumulator with B, en folds in X*W.
module conv_mac
  import conv_pkg::*;
#(
  parameter int INW  = 24,
  parameter int OUTW = 53
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_bias,
  input  logic                   en,
  input  logic signed [INW-1:0]  bias,
  input  logic signed [INW-1:0]  x,
  input  logic signed [INW-1:0]  w,
  output logic signed [OUTW-1:0] acc_nxt
);

  logic signed [2*INW-1:0] prod;
  logic signed [OUTW-1:0]  acc_q, acc_d;

  always_comb begin
    prod  = (2*INW)'(x) * (2*INW)'(w);
    acc_d = acc_q;
    if (load_bias)
      acc_d = {{(OUTW-INW){bias[INW-1]}}, bias};
    else if (en)
      acc_d = acc_q + {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
  end

  assign acc_nxt = acc_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/conv_engine.sv
// Window walker: issues X/W reads for each KxK window, accumulates via conv_mac, streams results on AXIS.
module conv_engine
  import conv_pkg::*;
#(
  parameter  int INW         = 24,
  parameter  int R           = 9,
  parameter  int C           = 8,
  parameter  int MAXK        = 4,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int X_ADDR_BITS = $clog2(R * C),
  localparam int W_ADDR_BITS = $clog2(MAXK * MAXK),
  localparam int OUTW        = conv_outw(INW, MAXK)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inputs_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic signed [INW-1:0]  B,
  output logic [X_ADDR_BITS-1:0] X_read_addr,
  input  logic signed [INW-1:0]  X_data,
  output logic [W_ADDR_BITS-1:0] W_read_addr,
  input  logic signed [INW-1:0]  W_data,
  output logic                   compute_finished,
  output logic signed [OUTW-1:0] AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY
);

  localparam int CNTW = $clog2((R > C) ? R : C) + 1;
  localparam logic [CNTW-1:0] RV    = CNTW'(R);
  localparam logic [CNTW-1:0] CV    = CNTW'(C);
  localparam logic [CNTW-1:0] MINRC = (R < C) ? CNTW'(R) : CNTW'(C);
  localparam logic [CNTW-1:0] ONE   = CNTW'(1);

  conv_state_t             st_q, st_d;
  logic [CNTW-1:0]         r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d, kk;
  logic [X_ADDR_BITS-1:0]  xa_q, xa_d;
  logic [W_ADDR_BITS-1:0]  wa_q, wa_d;
  logic signed [OUTW-1:0]  tdata_q, tdata_d, acc_nxt;
  logic                    tvalid_q, tvalid_d, done_q, done_d;
  logic                    load_bias, mac_en;

  conv_mac #(.INW(INW), .OUTW(OUTW)) u_mac (
    .clk       (clk),
    .reset     (reset),
    .load_bias (load_bias),
    .en        (mac_en),
    .bias      (B),
    .x         (X_data),
    .w         (W_data),
    .acc_nxt   (acc_nxt)
  );

  always_comb begin
    st_d      = st_q;
    r_d       = r_q;
    c_d       = c_q;
    i_d       = i_q;
    j_d       = j_q;
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    done_d    = 1'b0;
    load_bias = 1'b0;
    mac_en    = 1'b0;
    kk        = CNTW'(K);
    case (st_q)
      S_IDLE: if (inputs_loaded) begin
        if (kk != '0 && kk <= MINRC) begin
          st_d      = S_MAC;
          r_d       = '0;
          c_d       = '0;
          i_d       = '0;
          j_d       = '0;
          load_bias = 1'b1;
        end else begin
          st_d   = S_DONE;
          done_d = 1'b1;
        end
      end
      S_MAC: begin
        // Data for the first tap of a window arrives one cycle after its address.
        mac_en = (i_q != '0) || (j_q != '0);
        if (j_q == kk - ONE) begin
          if (i_q == kk - ONE) st_d = S_DRAIN;
          else begin
            j_d = '0;
            i_d = i_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      S_DRAIN: begin
        mac_en   = 1'b1;
        st_d     = S_OUT;
        tvalid_d = 1'b1;
        tdata_d  = acc_nxt;
      end
      S_OUT: if (AXIS_TREADY) begin
        tvalid_d = 1'b0;
        if (r_q == RV - kk && c_q == CV - kk) begin
          st_d   = S_DONE;
          done_d = 1'b1;
        end else begin
          st_d      = S_MAC;
          i_d       = '0;
          j_d       = '0;
          load_bias = 1'b1;
          if (c_q == CV - kk) begin
            c_d = '0;
            r_d = r_q + ONE;
          end else begin
            c_d = c_q + ONE;
          end
        end
      end
      S_DONE: if (!inputs_loaded) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    // Addresses are registered from the next-cycle indices so they line up with the MAC cycle.
    xa_d = X_ADDR_BITS'((32'(r_d) + 32'(i_d)) * 32'(C) + 32'(c_d) + 32'(j_d));
    wa_d = W_ADDR_BITS'(32'(i_d) * 32'(kk) + 32'(j_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q     <= S_IDLE;
      r_q      <= '0;
      c_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      xa_q     <= '0;
      wa_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      r_q      <= r_d;
      c_q      <= c_d;
      i_q      <= i_d;
      j_q      <= j_d;
      xa_q     <= xa_d;
      wa_q     <= wa_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
    end
  end

  assign X_read_addr      = xa_q;
  assign W_read_addr      = wa_q;
  assign AXIS_TDATA       = tdata_q;
  assign AXIS_TVALID      = tvalid_q;
  assign compute_finished = done_q;

endmodule

// File: tb/tb_conv_engine.sv
// Randomized bench for conv_engine against a nested-loop convolution model.
module tb_conv_engine;

  localparam int INW  = 24;
  localparam int R    = 9;
  localparam int C    = 8;
  localparam int OUTW = 2 * INW + 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   inputs_loaded;
  logic [2:0]             K;
  logic signed [INW-1:0]  B;
  logic [6:0]             X_read_addr;
  logic signed [INW-1:0]  X_data;
  logic [3:0]             W_read_addr;
  logic signed [INW-1:0]  W_data;
  logic                   compute_finished;
  logic signed [OUTW-1:0] AXIS_TDATA;
  logic                   AXIS_TVALID;
  logic                   AXIS_TREADY;

  conv_engine dut (
    .clk              (clk),
    .reset            (reset),
    .inputs_loaded    (inputs_loaded),
    .K                (K),
    .B                (B),
    .X_read_addr      (X_read_addr),
    .X_data           (X_data),
    .W_read_addr      (W_read_addr),
    .W_data           (W_data),
    .compute_finished (compute_finished),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TREADY      (AXIS_TREADY)
  );

  always #5 clk = ~clk;

  logic signed [INW-1:0] xmem [0:127];
  logic signed [INW-1:0] wmem [0:15];

  always @(posedge clk) begin
    X_data <= xmem[X_read_addr];
    W_data <= wmem[W_read_addr];
  end

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  longint exp_q[$];
  int beats, cf_cnt, first_tv, last_hs, job_k, job_n;
  bit gap_en = 0, rnd_ready = 0, stall_prev = 0;
  logic signed [OUTW-1:0] stall_data;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: direct sum over every valid window, row-major.
  task automatic build_exp(input int k, input longint b);
    exp_q.delete();
    if (k < 1 || k > 8) return;
    for (int r = 0; r <= R - k; r++)
      for (int c = 0; c <= C - k; c++) begin
        longint s = b;
        for (int i = 0; i < k; i++)
          for (int j = 0; j < k; j++)
            s += longint'(xmem[(r+i)*C + c + j]) * longint'(wmem[i*k + j]);
        exp_q.push_back(s);
      end
  endtask

  always @(negedge clk) begin
    if (stall_prev) begin
      chk("stall_tvalid", longint'(AXIS_TVALID), 1);
      chk("stall_tdata", longint'(AXIS_TDATA), longint'(stall_data));
    end
    stall_prev = AXIS_TVALID && !AXIS_TREADY;
    stall_data = AXIS_TDATA;
    if (compute_finished) cf_cnt++;
    if (AXIS_TVALID && first_tv < 0) first_tv = cyc;
    if (AXIS_TVALID && AXIS_TREADY) begin
      if (exp_q.size() == 0) chk("beat_over", beats + 1, job_n);
      else chk("beat", longint'(AXIS_TDATA), exp_q.pop_front());
      if (gap_en && last_hs >= 0) chk("beat_gap", cyc - last_hs, job_k * job_k + 2);
      last_hs = cyc;
      beats++;
    end
  end

  initial begin
    int rc = 0;
    AXIS_TREADY = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) begin
        rc++;
        if (rc >= 15 && rc < 25) AXIS_TREADY = 1'b0;
        else AXIS_TREADY = 1'($urandom_range(0, 1));
      end else begin
        rc = 0;
        AXIS_TREADY = 1'b1;
      end
    end
  end

  task automatic start_job(input int k, input int b, input bit rnd, input bit gap);
    K = k[2:0];
    B = b[INW-1:0];
    build_exp(k, longint'(b));
    job_k = k; job_n = exp_q.size();
    beats = 0; cf_cnt = 0; first_tv = -1; last_hs = -1;
    gap_en = gap; rnd_ready = rnd;
    @(posedge clk); #1;
    inputs_loaded = 1'b1;
  endtask

  task automatic run_job(input int k, input int b, input bit rnd, input bit gap, input int exp_n);
    int n = 0;
    int t0;
    start_job(k, b, rnd, gap);
    t0 = cyc;
    while (cf_cnt == 0 && n < 6000) begin @(posedge clk); n++; end
    chk("done_timeout", longint'(n < 6000), 1);
    repeat (6) @(posedge clk);
    #1;
    chk("beat_count", beats, exp_n);
    chk("beats_left", exp_q.size(), 0);
    chk("cf_once", cf_cnt, 1);
    if (exp_n > 0) chk("first_latency", first_tv - t0, k * k + 2);
    inputs_loaded = 1'b0;
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("cf_after_idle", cf_cnt, 1);
  endtask

  initial begin
    int n;
    reset = 1'b0; inputs_loaded = 1'b0; K = '0; B = '0;
    for (int a = 0; a < 128; a++) xmem[a] = '0;
    for (int a = 0; a < 16; a++) wmem[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", longint'(AXIS_TVALID), 0);
    chk("rst_tdata", longint'(AXIS_TDATA), 0);
    chk("rst_cf", longint'(compute_finished), 0);
    chk("rst_xaddr", longint'(X_read_addr), 0);
    chk("rst_waddr", longint'(W_read_addr), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int a = 0; a < 128; a++) xmem[a] = 24'sd1;
    for (int a = 0; a < 16; a++) wmem[a] = 24'sd1;
    run_job(2, 0, 0, 1, 56);

    for (int a = 0; a < 128; a++) xmem[a] = -24'sd1;
    for (int a = 0; a < 16; a++) wmem[a] = 24'sd3;
    run_job(3, -5, 0, 1, 42);

    for (int a = 0; a < 128; a++) xmem[a] = INW'(a);
    for (int a = 0; a < 16; a++) wmem[a] = 24'sd1;
    run_job(1, 0, 0, 1, 72);

    for (int a = 0; a < 128; a++) xmem[a] = 24'sh800000;
    for (int a = 0; a < 16; a++) wmem[a] = 24'sh800000;
    run_job(4, (1 << 23) - 1, 0, 1, 30);

    for (int a = 0; a < 128; a++) xmem[a] = INW'($urandom);
    for (int a = 0; a < 16; a++) wmem[a] = INW'($urandom);
    run_job(2, $urandom_range(0, (1 << 24) - 1) - (1 << 23), 1, 0, 56);
    run_job(3, $urandom_range(0, (1 << 24) - 1) - (1 << 23), 0, 1, 42);

    // Abort on the third beat, then a clean rerun.
    for (int a = 0; a < 128; a++) xmem[a] = 24'sd1;
    for (int a = 0; a < 16; a++) wmem[a] = 24'sd1;
    start_job(2, 0, 0, 0);
    n = 0;
    while (!(AXIS_TVALID && beats == 2) && n < 500) begin @(posedge clk); #2; n++; end
    chk("rst_wait_timeout", longint'(n < 500), 1);
    reset = 1'b0;
    #1 chk("rst_async_tvalid", longint'(AXIS_TVALID), 0);
    inputs_loaded = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("rst_no_cf", cf_cnt, 0);
    chk("rst_no_beats", beats, 2);
    run_job(2, 0, 0, 1, 56);

    run_job(0, 7, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
